// File: rtl/program_counter.sv
// program_counter: SR-1 16-bit PC with tri-state bus load and drive.
// Define PC_SATURATE_EN to clamp inc/dec at the range ends instead of wrapping.
module program_counter #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] data_bus,
  input  logic             increment,
  input  logic             decrement,
  input  logic             set,
  input  logic             read,
  input  logic             reset_instr
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_dec;
  logic             drive;

  // step candidates, wrapping or clamped at the ends
  always_comb begin
    pc_inc = pc_q + ONE;
    pc_dec = pc_q - ONE;
`ifdef PC_SATURATE_EN
    if (&pc_q) begin
      pc_inc = pc_q;
    end
    if (~|pc_q) begin
      pc_dec = pc_q;
    end
`endif
  end

  // command priority: reset_instr, set, inc/dec, hold
  always_comb begin
    pc_d = pc_q;
    if (reset_instr) begin
      pc_d = RESET_VECTOR;
    end else if (set) begin
      pc_d = data_bus;
    end else if (increment && !decrement) begin
      pc_d = pc_inc;
    end else if (decrement && !increment) begin
      pc_d = pc_dec;
    end
  end

  // PC register with async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  // set blocks the drive so a load never captures our own value
  assign drive    = read && !set && reset;
  assign data_bus = drive ? pc_q : 'z;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed stimulus, bench-side model and bus checks.
// Undriven bus reads all-ones through pull-ups.
module tb_program_counter;

  localparam int W = 16;

  logic clk         = 1'b0;
  logic reset       = 1'b0;
  logic increment   = 1'b0;
  logic decrement   = 1'b0;
  logic set         = 1'b0;
  logic read        = 1'b0;
  logic reset_instr = 1'b0;
  logic drv_en      = 1'b0;
  logic [W-1:0] drv = '0;

  wire [W-1:0] data_bus;

  assign data_bus = drv_en ? drv : 'z;

  for (genvar i = 0; i < W; i++) begin : g_pu
    pullup pu (data_bus[i]);
  end

  program_counter #(
    .WIDTH        (W),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_bus    (data_bus),
    .increment   (increment),
    .decrement   (decrement),
    .set         (set),
    .read        (read),
    .reset_instr (reset_instr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] pc_m = '0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_bus();
    if (reset && read && !set) return pc_m;
    return 16'hFFFF;
  endfunction

  // specification model: integer arithmetic on the architectural PC
  always @(posedge clk or negedge reset) begin
    int v;
    if (!reset) begin
      pc_m = 16'h0000;
    end else if (reset_instr) begin
      pc_m = 16'h0000;
    end else if (set) begin
      pc_m = data_bus;
    end else if (increment != decrement) begin
      v = int'(pc_m) + (increment ? 1 : -1);
`ifdef PC_SATURATE_EN
      if (v > 65535) v = 65535;
      if (v < 0) v = 0;
`else
      v = (v + 65536) % 65536;
`endif
      pc_m = v[W-1:0];
    end
  end

  // continuous compare whenever the bench is not driving the bus
  always @(negedge clk) begin
    if (!drv_en) chk("bus_model", data_bus, exp_bus());
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [W-1:0] v);
    drv    = v;
    drv_en = 1'b1;
    set    = 1'b1;
    cyc(1);
    set    = 1'b0;
    drv_en = 1'b0;
  endtask

  initial begin
    read = 1'b1;
    cyc(2);
    #1 chk("reset_bus_z", data_bus, 16'hFFFF);
    reset = 1'b1;
    #1 chk("reset_vector", data_bus, 16'h0000);

    increment = 1'b1;
    cyc(5);
    #1 chk("inc5", data_bus, 16'h0005);
    increment = 1'b0;
    decrement = 1'b1;
    cyc(2);
    #1 chk("dec2", data_bus, 16'h0003);
    increment = 1'b1;
    cyc(3);
    #1 chk("both_hold", data_bus, 16'h0003);
    increment = 1'b0;
    decrement = 1'b0;

    drv    = 16'h1234;
    drv_en = 1'b1;
    set    = 1'b1;
    #1 chk("set_no_drive", data_bus, 16'h1234);
    cyc(1);
    set    = 1'b0;
    drv_en = 1'b0;
    #1 chk("load_1234", data_bus, 16'h1234);
    read = 1'b0;
    #1 chk("read0_z", data_bus, 16'hFFFF);
    read = 1'b1;

    load(16'h0040);
    reset_instr = 1'b1;
    increment   = 1'b1;
    #1 chk("rinstr_old", data_bus, 16'h0040);
    cyc(1);
    reset_instr = 1'b0;
    increment   = 1'b0;
    #1 chk("rinstr_vec", data_bus, 16'h0000);

    increment = 1'b1;
    cyc(3);
    increment = 1'b0;
    chk("pre_async", data_bus, 16'h0003);
    reset = 1'b0;
    #1 chk("async_z", data_bus, 16'hFFFF);
    reset = 1'b1;
    #1 chk("async_vec", data_bus, 16'h0000);

    load(16'hFFFF);
    increment = 1'b1;
    cyc(1);
    increment = 1'b0;
`ifdef PC_SATURATE_EN
    #1 chk("inc_top", data_bus, 16'hFFFF);
`else
    #1 chk("inc_top", data_bus, 16'h0000);
`endif

    load(16'h0000);
    decrement = 1'b1;
    cyc(1);
    decrement = 1'b0;
`ifdef PC_SATURATE_EN
    #1 chk("dec_bottom", data_bus, 16'h0000);
`else
    #1 chk("dec_bottom", data_bus, 16'hFFFF);
`endif

    load(16'h8000);
    decrement = 1'b1;
    cyc(1);
    decrement = 1'b0;
    #1 chk("dec_mid", data_bus, 16'h7FFF);
    set = 1'b1;
    drv_en = 1'b1;
    drv = 16'hABCD;
    reset_instr = 1'b1;
    cyc(1);
    set = 1'b0;
    drv_en = 1'b0;
    reset_instr = 1'b0;
    #1 chk("rinstr_over_set", data_bus, 16'h0000);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
